// File: rtl/interrupt_controller_if.sv
// CPU I/O bus shared by the interrupt controller and other bus peripherals.
// The CPU side drives address/control/write data; peripherals return read data.
interface interrupt_controller_if;
    logic [31:0] addressBus;
    logic        mio;
    logic [7:0]  dataBusIn;
    logic [7:0]  dataBusOut;
    logic        readRequest;
    logic        enable;

    modport master (
        output addressBus,
        output mio,
        output dataBusIn,
        output readRequest,
        output enable,
        input  dataBusOut
    );

    modport slave (
        input  addressBus,
        input  mio,
        input  dataBusIn,
        input  readRequest,
        input  enable,
        output dataBusOut
    );
endinterface

// File: rtl/interrupt_controller.sv
// 16-line edge-triggered interrupt controller with mask, pending and EOI.
// Presents the lowest-numbered unmasked pending line to the CPU.
module interrupt_controller #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            externalInterrupts,
    interrupt_controller_if.slave  bus,
    output logic                   interruptRequest,
    output logic [3:0]             interruptVector,
    input  logic                   interruptAcknowledge
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] prev_lines_q, prev_lines_d;
    logic [3:0]  current_vector_q, current_vector_d;
    logic        in_service_q, in_service_d;
    logic [7:0]  data_out_q, data_out_d;

    logic [31:0] addr_off;
    logic [2:0]  off;
    logic        sel;
    logic        rd_sel;
    logic        wr_sel;
    logic        eoi;
    logic [15:0] new_edges;
    logic [15:0] eligible;
    logic [15:0] w1c;
    logic [15:0] ack_clear;
    logic [3:0]  first_idx;
    logic [7:0]  rd_data;

    // Unsigned wrap makes addresses below the base fall out of range.
    assign addr_off = bus.addressBus - BASE_ADDRESS;
    assign off      = addr_off[2:0];
    assign sel      = bus.enable & ~bus.mio & (addr_off < 32'd5);
    assign rd_sel   = sel & bus.readRequest;
    assign wr_sel   = sel & ~bus.readRequest;
    assign eoi      = wr_sel & (off == 3'd4);

    assign new_edges = externalInterrupts & ~prev_lines_q;
    assign eligible  = pending_q & ~mask_q;

    always_comb begin
        first_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (eligible[i]) first_idx = 4'(i);
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (off)
            3'd0: rd_data = mask_q[7:0];
            3'd1: rd_data = mask_q[15:8];
            3'd2: rd_data = pending_q[7:0];
            3'd3: rd_data = pending_q[15:8];
            3'd4: rd_data = {in_service_q, 3'b000, current_vector_q};
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        mask_d       = mask_q;
        w1c          = 16'h0000;
        ack_clear    = 16'h0000;
        prev_lines_d = externalInterrupts;
        data_out_d   = rd_sel ? rd_data : 8'h00;
        if (wr_sel && off == 3'd0) mask_d[7:0]  = bus.dataBusIn;
        if (wr_sel && off == 3'd1) mask_d[15:8] = bus.dataBusIn;
        if (wr_sel && off == 3'd2) w1c[7:0]     = bus.dataBusIn;
        if (wr_sel && off == 3'd3) w1c[15:8]    = bus.dataBusIn;
        if (state_q == REQUEST && interruptAcknowledge) begin
            ack_clear = 16'h0001 << current_vector_q;
        end
        // A fresh edge always wins over any clear in the same cycle.
        pending_d = (pending_q & ~w1c & ~ack_clear) | new_edges;
    end

    always_comb begin
        state_d          = state_q;
        current_vector_d = current_vector_q;
        in_service_d     = in_service_q;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    current_vector_d = first_idx;
                    state_d          = REQUEST;
                end
            end
            REQUEST: begin
                if (interruptAcknowledge) begin
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end else if (!eligible[current_vector_q]) begin
                    current_vector_d = 4'd0;
                    state_d          = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d     = 1'b0;
                    current_vector_d = 4'd0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            mask_q           <= 16'hFFFF;
            pending_q        <= 16'h0000;
            prev_lines_q     <= 16'h0000;
            current_vector_q <= 4'd0;
            in_service_q     <= 1'b0;
            data_out_q       <= 8'h00;
        end else begin
            state_q          <= state_d;
            mask_q           <= mask_d;
            pending_q        <= pending_d;
            prev_lines_q     <= prev_lines_d;
            current_vector_q <= current_vector_d;
            in_service_q     <= in_service_d;
            data_out_q       <= data_out_d;
        end
    end

    assign interruptRequest = (state_q == REQUEST);
    assign interruptVector  = interruptRequest ? current_vector_q : 4'd0;
    assign bus.dataBusOut   = data_out_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: vector table, directed corner cases,
// then random traffic against a behavioural model.
module tb_interrupt_controller;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clock;
    logic        reset;
    logic [15:0] ext;
    logic        ack;
    logic        interruptRequest;
    logic [3:0]  interruptVector;

    interrupt_controller_if bus ();

    interrupt_controller #(.BASE_ADDRESS(BASE)) dut (
        .clock                (clock),
        .reset                (reset),
        .externalInterrupts   (ext),
        .bus                  (bus),
        .interruptRequest     (interruptRequest),
        .interruptVector      (interruptVector),
        .interruptAcknowledge (ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    logic [15:0] m_mask, m_pend, m_prev;
    bit          m_req, m_svc;
    logic [3:0]  m_vec;
    logic [7:0]  m_out;

    typedef struct {
        bit          en;
        bit          rd;
        int          off;
        logic [7:0]  din;
        logic [15:0] ext;
        bit          ack;
        bit          exp_req;
        logic [3:0]  exp_vec;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t tbl[14];

    task automatic model_reset();
        m_mask = 16'hFFFF;
        m_pend = 16'h0;
        m_prev = 16'h0;
        m_req  = 0;
        m_svc  = 0;
        m_vec  = 4'd0;
        m_out  = 8'h00;
    endtask

    task automatic model_step();
        logic [31:0] off;
        bit          sel, rd, wr;
        logic [15:0] edges, elig, gone;
        logic [7:0]  rv;
        off   = bus.addressBus - BASE;
        sel   = bus.enable && !bus.mio && (off < 5);
        rd    = sel && bus.readRequest;
        wr    = sel && !bus.readRequest;
        case (off)
            0: rv = m_mask[7:0];
            1: rv = m_mask[15:8];
            2: rv = m_pend[7:0];
            3: rv = m_pend[15:8];
            4: rv = {m_svc, 3'b000, m_vec};
            default: rv = 8'h00;
        endcase
        m_out = rd ? rv : 8'h00;
        edges = ext & ~m_prev;
        elig  = m_pend & ~m_mask;
        gone  = 16'h0;
        if (wr && off == 2) gone[7:0]  = bus.dataBusIn;
        if (wr && off == 3) gone[15:8] = bus.dataBusIn;
        if (m_req) begin
            if (ack) begin
                gone[m_vec] = 1'b1;
                m_req = 0;
                m_svc = 1;
            end else if (!elig[m_vec]) begin
                m_req = 0;
                m_vec = 4'd0;
            end
        end else if (m_svc) begin
            if (wr && off == 4) begin
                m_svc = 0;
                m_vec = 4'd0;
            end
        end else if (elig != 16'h0) begin
            m_req = 1;
            for (int i = 0; i < 16; i++) begin
                if (elig[i]) begin
                    m_vec = 4'(i);
                    break;
                end
            end
        end
        m_pend = (m_pend & ~gone) | edges;
        if (wr && off == 0) m_mask[7:0]  = bus.dataBusIn;
        if (wr && off == 1) m_mask[15:8] = bus.dataBusIn;
        m_prev = ext;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drive_bus(input bit en, input bit rd,
                             input logic [31:0] addr, input bit mio,
                             input logic [7:0] d);
        bus.enable      = en;
        bus.readRequest = rd;
        bus.addressBus  = addr;
        bus.mio         = mio;
        bus.dataBusIn   = d;
    endtask

    task automatic acc(input bit rd, input int off, input logic [7:0] d);
        drive_bus(1'b1, rd, BASE + 32'(off), 1'b0, d);
    endtask

    task automatic idle();
        drive_bus(1'b0, 1'b1, BASE, 1'b0, 8'h00);
    endtask

    task automatic check(input string name, input bit er,
                         input logic [3:0] ev, input logic [7:0] eo);
        checks++;
        if (interruptRequest !== er || interruptVector !== ev ||
            bus.dataBusOut !== eo) begin
            failures++;
            $display("FAIL %s: got req=%0b vec=%0d out=%h, expected req=%0b vec=%0d out=%h",
                     name, interruptRequest, interruptVector, bus.dataBusOut,
                     er, ev, eo);
        end
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 8'h00, 16'h0000, 0, 0, 4'd0, 8'hFF};
        tbl[1]  = '{1, 1, 1, 8'h00, 16'h0000, 0, 0, 4'd0, 8'hFF};
        tbl[2]  = '{1, 1, 2, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h00};
        tbl[3]  = '{1, 1, 3, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h00};
        tbl[4]  = '{1, 1, 4, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h00};
        tbl[5]  = '{1, 0, 0, 8'hEF, 16'h0000, 0, 0, 4'd0, 8'h00};
        tbl[6]  = '{0, 1, 0, 8'h00, 16'h0010, 0, 0, 4'd0, 8'h00};
        tbl[7]  = '{1, 1, 2, 8'h00, 16'h0010, 0, 1, 4'd4, 8'h10};
        tbl[8]  = '{0, 1, 0, 8'h00, 16'h0010, 0, 1, 4'd4, 8'h00};
        tbl[9]  = '{0, 1, 0, 8'h00, 16'h0010, 1, 0, 4'd0, 8'h00};
        tbl[10] = '{1, 1, 4, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h84};
        tbl[11] = '{1, 1, 2, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h00};
        tbl[12] = '{1, 0, 4, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h00};
        tbl[13] = '{1, 1, 4, 8'h00, 16'h0000, 0, 0, 4'd0, 8'h00};

        reset = 1'b1;
        ext   = 16'h0;
        ack   = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset", 0, 4'd0, 8'h00);
        reset = 1'b0;

        // Register reads after reset and the single-line walkthrough.
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].en) acc(tbl[i].rd, tbl[i].off, tbl[i].din);
            else idle();
            ext = tbl[i].ext;
            ack = tbl[i].ack;
            tick();
            check($sformatf("tbl%0d", i), tbl[i].exp_req,
                  tbl[i].exp_vec, tbl[i].exp_out);
        end
        ack = 0;
        idle();

        // Two simultaneous edges: priority then post-EOI request.
        acc(0, 0, 8'h00); tick();
        acc(0, 1, 8'h00); tick();
        idle(); ext = 16'h0204; tick();
        check("prio_pend", 0, 4'd0, 8'h00);
        tick();
        check("prio_first", 1, 4'd2, 8'h00);
        ack = 1; tick(); ack = 0;
        check("prio_ack", 0, 4'd0, 8'h00);
        acc(0, 4, 8'h00); tick(); idle();
        check("prio_eoi", 0, 4'd0, 8'h00);
        tick();
        check("prio_second", 1, 4'd9, 8'h00);
        ack = 1; tick(); ack = 0;
        acc(0, 4, 8'h00); tick(); idle();
        ext = 16'h0; tick();

        // Masked line stays pending until unmasked.
        acc(0, 0, 8'h20); tick(); idle();
        ext = 16'h0020; tick();
        ext = 16'h0000; tick();
        acc(1, 2, 8'h00); tick(); idle();
        check("mask_pend", 0, 4'd0, 8'h20);
        acc(0, 0, 8'h00); tick(); idle();
        check("mask_wr", 0, 4'd0, 8'h00);
        tick();
        check("mask_req", 1, 4'd5, 8'h00);
        ack = 1; tick(); ack = 0;
        acc(0, 4, 8'h00); tick(); idle();
        tick();

        // Clearing the requested bit withdraws the request.
        ext = 16'h0008; tick(); tick();
        check("wd_req", 1, 4'd3, 8'h00);
        acc(0, 2, 8'h08); tick(); idle();
        tick();
        check("wd_gone", 0, 4'd0, 8'h00);
        acc(1, 4, 8'h00); tick(); idle();
        check("wd_status", 0, 4'd0, 8'h00);
        ext = 16'h0; tick();

        // Asynchronous reset during service, line held through reset.
        ext = 16'h0080; tick(); tick();
        check("rst_req", 1, 4'd7, 8'h00);
        ack = 1; tick(); ack = 0;
        acc(1, 4, 8'h00); tick();
        check("rst_svc", 0, 4'd0, 8'h87);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_async", 0, 4'd0, 8'h00);
        idle();
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        acc(1, 2, 8'h00); tick();
        check("rst_edge", 0, 4'd0, 8'h80);
        acc(1, 0, 8'h00); tick(); idle();
        check("rst_mask", 0, 4'd0, 8'hFF);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) ext[$urandom_range(0, 15)] ^= 1'b1;
            ack = m_req && ($urandom_range(0, 2) == 0);
            if (r < 4) begin
                idle();
            end else if (r < 6) begin
                acc(1, int'($urandom_range(0, 4)), 8'h00);
            end else if (r < 9) begin
                int o;
                logic [7:0] d;
                o = int'($urandom_range(0, 4));
                d = 8'($urandom);
                if (o < 2 && $urandom_range(0, 1) == 0) d = 8'h00;
                acc(0, o, d);
            end else begin
                case ($urandom_range(0, 2))
                    0: drive_bus(1'b1, 1'($urandom), BASE, 1'b1, 8'($urandom));
                    1: drive_bus(1'b1, 1'($urandom), BASE + 32'd5, 1'b0, 8'($urandom));
                    default: drive_bus(1'b1, 1'($urandom), BASE - 32'd1, 1'b0, 8'($urandom));
                endcase
            end
            tick();
            check("rand", m_req, m_req ? m_vec : 4'd0, m_out);
        end
        ack = 0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Memory-mapped 16-line interrupt controller between the board's raw `externalInterrupts` lines and the CPU's interrupt request/acknowledge pins. It detects rising edges on each line, latches them as pending and applies a software-programmable mask. It then presents the highest-priority unmasked request to the CPU as a 4-bit vector and blocks further requests until the handler writes end-of-interrupt. Mask, pending and status registers sit on the shared CPU I/O bus alongside the seven-segment and LED controllers.

## Interface
- `BASE_ADDRESS`, default 32'h0000_0100: I/O-space base; registers occupy BASE..BASE+4.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `externalInterrupts`  in  16  raw interrupt lines, synchronous to `clock`; bit 0 has highest priority.
- `addressBus`  in  32  CPU address.
- `mio`  in  1  0 = I/O space (the block responds only when 0), 1 = memory.
- `dataBusIn`  in  8  CPU write data.
- `dataBusOut`  out  8  register read data.
- `readRequest`  in  1  1 = read, 0 = write; qualified by `enable`.
- `enable`  in  1  bus cycle valid this clock.
- `interruptRequest`  out  1  request to the CPU.
- `interruptVector`  out  4  index of the requested line, stable while `interruptRequest`=1.
- `interruptAcknowledge`  in  1  single-cycle CPU acknowledge.

## Operation
- Select = `enable` & ~`mio` & address in BASE..BASE+4.
- Register map by offset:
  - 0 MASK[7:0], R/W.
  - 1 MASK[15:8], R/W.
  - 2 PENDING[7:0], R and write-1-to-clear.
  - 3 PENDING[15:8], R and write-1-to-clear.
  - 4 STATUS, read {inService, 3'b0, currentVector}. Any write to offset 4 is EOI.
- Mask bit = 1 blocks that line.
- Edge detect: `prevLines` register. A bit is new when line=1 and prev=0. A new edge sets the PENDING bit regardless of mask.
- FSM, 3 states:
  - IDLE: if PENDING & ~MASK ≠ 0, latch the lowest set index into `currentVector` and go to REQUEST.
  - REQUEST: `interruptRequest`=1.
    - On `interruptAcknowledge`: clear PENDING[currentVector], set inService, go to SERVICE.
    - If the selected bit becomes masked or cleared before the acknowledge: withdraw to IDLE with no acknowledge needed.
  - SERVICE: request low, no nesting. On an EOI write: clear inService, go to IDLE.
  - EOI outside SERVICE is ignored.
- A higher-priority edge arriving during REQUEST does not replace the latched vector; it stays pending.
- Simultaneous edge and write-1-to-clear on the same bit: set wins.
- Simultaneous acknowledge and a new edge on the same line: the acknowledged edge is cleared and the new edge re-sets PENDING, so it is serviced again later.
- Reset values:
  - MASK=16'hFFFF.
  - PENDING=0, prevLines=0, state IDLE, currentVector=0, inService=0.
  - `interruptRequest`=0, `interruptVector`=0, `dataBusOut`=8'h00.
- Reset mid-operation aborts any request or service immediately (asynchronous). Lines already high at reset release produce an edge on the first cycle.

## Timing
- Line rises before edge k: PENDING set at edge k. Request latched at edge k+1, so `interruptRequest` is high 2 cycles after the line rises (if unmasked).
- `interruptVector` is registered with the request and equals `currentVector` while the request is high; it is 0 in IDLE.
- Acknowledge sampled at edge a: request low after edge a.
- EOI write sampled at edge e: IDLE after e. The next pending request is raised after edge e+1.
- Read: `dataBusOut` is registered and valid the cycle after a selected read. It returns to 8'h00 the cycle after a non-read or unselected cycle.
- Write: takes effect at the edge where the write is sampled. A mask write affects FSM selection from the next edge.
- Bus reads and writes are single-cycle with no wait states; back-to-back accesses are supported.

## Test plan
- Reset, then read offsets 0..4 → FF, FF, 00, 00, 00; `interruptRequest`=0.
- Write MASK_LO=8'hEF, then pulse line 4 high for 4 cycles → PENDING_LO=8'h10 and request high 2 cycles after the rise with vector 4. Acknowledge → request low, STATUS=8'h84, PENDING_LO=0. EOI write → STATUS=8'h00.
- MASK=0, raise lines 9 and 2 in the same cycle → vector 2 first. After acknowledge+EOI, vector 9 is requested one cycle after EOI.
- Line 5 masked (MASK_LO=8'h20), pulse line 5 → PENDING_LO=8'h20 and no request. Write MASK_LO=0 → request, vector 5.
- In REQUEST for vector 3, write-1-to-clear PENDING_LO=8'h08 before acknowledge → request withdrawn next cycle, state IDLE, no service.
- Assert `reset` during SERVICE → all outputs and registers return to their reset values at once. A line held high through reset triggers PENDING on the first cycle after release.
